// File: rtl/clk_ratio_monitor.sv
// clk_ratio_monitor: measures the period and high-phase width of a divided
// clock in reference-clock cycles, and flags lock (stable ratio) and timeout
// (no edge for 255 cycles in the current phase).
module clk_ratio_monitor #(
    parameter int LOCK_CNT = 4  // consecutive matching periods for lock, 2..15
) (
    input  logic       I_ref_clk,
    input  logic       I_rst,
    input  logic       I_en,
    input  logic       I_div_clk,
    output logic [7:0] O_ratio,
    output logic [7:0] O_high_cnt,
    output logic       O_meas_valid,
    output logic       O_locked,
    output logic       O_timeout
);

    localparam logic [3:0] LOCK_W = 4'(LOCK_CNT);

    typedef enum logic [1:0] {IDLE, HIGH, LOW, TMO} state_t;

    state_t     state;
    logic       s1, s2, s3;
    logic [2:0] vld_pipe;
    logic       rise, fall;
    logic [7:0] hi_cnt, lo_cnt;
    logic [3:0] match_cnt;
    logic [3:0] match_nxt;
    logic [8:0] sum9;
    logic [7:0] meas_ratio;

    // Sync chain plus a fill marker: edges are only trusted once s3 holds a
    // real sample, so a clock already high at reset release is not a rise.
    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            vld_pipe <= '0;
        end else begin
            s1       <= I_div_clk;
            s2       <= s1;
            s3       <= s2;
            vld_pipe <= {vld_pipe[1:0], 1'b1};
        end
    end

    assign rise = vld_pipe[2] &  s2 & ~s3;
    assign fall = vld_pipe[2] & ~s2 &  s3;

    // Period measurement (saturating) and next repeat count for the lock test.
    always_comb begin
        sum9       = {1'b0, hi_cnt} + {1'b0, lo_cnt};
        meas_ratio = sum9[8] ? 8'hFF : sum9[7:0];
        match_nxt  = 4'd1;
        if (match_cnt != 4'd0 && meas_ratio == O_ratio)
            match_nxt = (match_cnt >= LOCK_W) ? LOCK_W : match_cnt + 4'd1;
    end

    // Phase FSM: counts high/low phases, emits a measurement on each rise
    // that closes a complete period, and tracks lock and timeout.
    always_ff @(posedge I_ref_clk) begin
        if (I_rst) begin
            state        <= IDLE;
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            match_cnt    <= '0;
            O_ratio      <= '0;
            O_high_cnt   <= '0;
            O_meas_valid <= 1'b0;
            O_locked     <= 1'b0;
            O_timeout    <= 1'b0;
        end else if (!I_en) begin
            state        <= IDLE;
            hi_cnt       <= '0;
            lo_cnt       <= '0;
            match_cnt    <= '0;
            O_meas_valid <= 1'b0;
            O_locked     <= 1'b0;
            O_timeout    <= 1'b0;
        end else begin
            O_meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise) begin
                        hi_cnt <= 8'd1;
                        lo_cnt <= '0;
                        state  <= HIGH;
                    end
                end
                HIGH: begin
                    if (fall) begin
                        lo_cnt <= 8'd1;
                        state  <= LOW;
                    end else if (hi_cnt == 8'hFF) begin
                        state     <= TMO;
                        O_timeout <= 1'b1;
                        match_cnt <= '0;
                        O_locked  <= 1'b0;
                        hi_cnt    <= '0;
                        lo_cnt    <= '0;
                    end else begin
                        hi_cnt <= hi_cnt + 8'd1;
                    end
                end
                LOW: begin
                    if (rise) begin
                        O_ratio      <= meas_ratio;
                        O_high_cnt   <= hi_cnt;
                        O_meas_valid <= 1'b1;
                        match_cnt    <= match_nxt;
                        O_locked     <= (match_nxt == LOCK_W);
                        hi_cnt       <= 8'd1;
                        lo_cnt       <= '0;
                        state        <= HIGH;
                    end else if (lo_cnt == 8'hFF) begin
                        state     <= TMO;
                        O_timeout <= 1'b1;
                        match_cnt <= '0;
                        O_locked  <= 1'b0;
                        hi_cnt    <= '0;
                        lo_cnt    <= '0;
                    end else begin
                        lo_cnt <= lo_cnt + 8'd1;
                    end
                end
                TMO: begin
                    // a fall here is ignored; only a rise restarts counting
                    if (rise) begin
                        O_timeout <= 1'b0;
                        hi_cnt    <= 8'd1;
                        lo_cnt    <= '0;
                        state     <= HIGH;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clk_ratio_monitor.sv
// Scoreboard bench for clk_ratio_monitor: stimulus is described as high/low
// phases; a phase-level model predicts each measurement and its cycle.
module tb_clk_ratio_monitor;

    localparam int LOCK_CNT = 4;

    logic       clk = 1'b0;
    logic       rst, en, div;
    logic [7:0] O_ratio, O_high_cnt;
    logic       O_meas_valid, O_locked, O_timeout;

    clk_ratio_monitor #(.LOCK_CNT(LOCK_CNT)) dut (
        .I_ref_clk   (clk),
        .I_rst       (rst),
        .I_en        (en),
        .I_div_clk   (div),
        .O_ratio     (O_ratio),
        .O_high_cnt  (O_high_cnt),
        .O_meas_valid(O_meas_valid),
        .O_locked    (O_locked),
        .O_timeout   (O_timeout)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct { int cyc; int ratio; int high; bit locked; } exp_t;
    typedef struct { int cyc; int which; int val; } fexp_t;
    exp_t  q[$];
    fexp_t fq[$];

    // phase-level reference model
    bit m_started = 0, m_have_lo = 0;
    int m_hi = 0, m_lo = 0, m_match = 0, m_prev = 0, m_prev_hi = 0;

    task automatic chk(input string name, input int act, input int exp_v);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    function automatic string fname(input int w);
        case (w)
            0: return "meas_valid";
            1: return "locked";
            2: return "timeout";
            3: return "ratio";
            default: return "high_cnt";
        endcase
    endfunction

    function automatic int fval(input int w);
        case (w)
            0: return int'(O_meas_valid);
            1: return int'(O_locked);
            2: return int'(O_timeout);
            3: return int'(O_ratio);
            default: return int'(O_high_cnt);
        endcase
    endfunction

    task automatic push_flag(input int c, input int w, input int v);
        fexp_t f;
        f.cyc = c; f.which = w; f.val = v;
        fq.push_back(f);
    endtask

    task automatic m_clear(input bit keep_out);
        m_started = 0; m_have_lo = 0; m_match = 0;
        if (!keep_out) begin m_prev = 0; m_prev_hi = 0; end
    endtask

    // A rise closes the previous full period (if any) and opens a new one.
    task automatic m_rise(input int c, input int len);
        exp_t e;
        int   r;
        if (m_started && m_have_lo) begin
            r = m_hi + m_lo;
            if (r > 255) r = 255;
            if (m_match == 0)    m_match = 1;
            else if (r == m_prev) m_match = (m_match < LOCK_CNT) ? m_match + 1 : LOCK_CNT;
            else                 m_match = 1;
            m_prev = r; m_prev_hi = m_hi;
            e.cyc = c + 3; e.ratio = r; e.high = m_hi; e.locked = (m_match == LOCK_CNT);
            q.push_back(e);
        end
        m_have_lo = 0;
        if (len > 255) m_clear(1);
        else begin m_started = 1; m_hi = len; end
    endtask

    task automatic m_fall(input int len);
        if (m_started) begin
            if (len > 255) m_clear(1);
            else begin m_lo = len; m_have_lo = 1; end
        end
    endtask

    // Drive one phase; new_edge=0 continues the current level without an edge.
    task automatic drive_phase(input bit lvl, input int len, input bit new_edge);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (i == 0 && new_edge) begin
                if (lvl) m_rise(cyc, len);
                else     m_fall(len);
            end
            div = lvl;
        end
    endtask

    task automatic period(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            drive_phase(1'b1, h, 1'b1);
            drive_phase(1'b0, l, 1'b1);
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        m_clear(0);
        for (int w = 0; w < 5; w++) push_flag(cyc + 1, w, 0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic drop_enable();
        @(negedge clk);
        en = 1'b0;
        m_clear(1);
        push_flag(cyc + 1, 0, 0);
        push_flag(cyc + 1, 1, 0);
        push_flag(cyc + 1, 2, 0);
        push_flag(cyc + 1, 3, m_prev);
        push_flag(cyc + 1, 4, m_prev_hi);
        @(negedge clk);
        @(negedge clk);
        en = 1'b1;
    endtask

    // Monitor: pops expected measurements on each pulse and checks flag points.
    always @(negedge clk) begin
        exp_t  e;
        fexp_t f;
        if (O_meas_valid) begin
            if (q.size() == 0) begin
                checks++; errors++;
                $display("FAIL meas_unexpected: pulse at cycle %0d ratio %0d, expected no pulse", cyc, O_ratio);
            end else begin
                e = q.pop_front();
                chk("meas_cycle", cyc, e.cyc);
                chk("meas_ratio", O_ratio, e.ratio);
                chk("meas_high", O_high_cnt, e.high);
                chk("meas_locked", O_locked, e.locked);
            end
        end else if (q.size() > 0 && q[0].cyc < cyc) begin
            e = q.pop_front();
            checks++; errors++;
            $display("FAIL meas_missing: no pulse by cycle %0d, expected at %0d ratio %0d", cyc, e.cyc, e.ratio);
        end
        while (fq.size() > 0 && fq[0].cyc <= cyc) begin
            f = fq.pop_front();
            chk(fname(f.which), fval(f.which), f.val);
        end
    end

    initial begin
        int h, l, n, c;
        rst = 1'b1; en = 1'b0; div = 1'b0;
        repeat (2) @(negedge clk);
        for (int w = 0; w < 5; w++) push_flag(cyc + 1, w, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0; en = 1'b1;
        drive_phase(1'b0, 6, 1'b1);

        // ratio 6, 7, 2
        period(3, 3, 6);
        period(3, 4, 5);
        period(1, 1, 6);

        // lock at 4, then switch to 9 and relock
        period(2, 2, 5);
        period(4, 5, 6);

        // stuck low after lock: timeout on the 256th low cycle
        drive_phase(1'b1, 4, 1'b1);
        c = cyc + 1;
        push_flag(c + 257, 1, (m_match == LOCK_CNT) ? 1 : 0);
        push_flag(c + 257, 2, 0);
        push_flag(c + 258, 1, 0);
        push_flag(c + 258, 2, 1);
        drive_phase(1'b0, 300, 1'b1);

        // restart at ratio 4: timeout clears with the first rise
        c = cyc + 1;
        push_flag(c + 2, 2, 1);
        push_flag(c + 3, 2, 0);
        period(2, 2, 5);

        // long periods: saturation, and exact 255-cycle phases without timeout
        period(200, 200, 2);
        push_flag(cyc + 1, 2, 0);
        period(255, 255, 2);
        push_flag(cyc + 1, 2, 0);
        period(5, 5, 3);
        // a 256-cycle high phase times out; the following fall is ignored
        period(256, 3, 1);
        period(3, 2, 4);

        // randomized bursts of repeated ratios
        for (int b = 0; b < 25; b++) begin
            h = $urandom_range(1, 10);
            l = $urandom_range(1, 10);
            n = $urandom_range(1, 6);
            period(h, l, n);
        end

        // reset mid-HIGH, then recovery
        period(3, 3, 5);
        drive_phase(1'b1, 5, 1'b1);
        pulse_reset();
        drive_phase(1'b1, 3, 1'b0);
        drive_phase(1'b0, 3, 1'b1);
        period(3, 3, 5);

        // enable drop mid-HIGH, then recovery
        drive_phase(1'b1, 5, 1'b1);
        drop_enable();
        drive_phase(1'b1, 3, 1'b0);
        drive_phase(1'b0, 3, 1'b1);
        period(4, 3, 5);

        drive_phase(1'b0, 10, 1'b1);
        repeat (5) @(negedge clk);
        chk("meas_queue_drained", q.size(), 0);
        chk("flag_queue_drained", fq.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clk_ratio_monitor.md
# clk_ratio_monitor

Measures a divided clock against the reference clock and reports its division ratio and high-phase width in reference cycles. It is the receive-side checker for the programmable clock divider. It sits on the `I_ref_clk` domain, and its input is sampled as data through a 2-flop synchronizer. Lock and timeout flags let control logic confirm that a programmed ratio took effect, or detect a stopped or bypassed clock.

## Interface
- `LOCK_CNT`, default 4: number of consecutive identical period measurements required to assert `O_locked` (range 2..15).
- `I_ref_clk` in 1: reference clock; all logic on its rising edge.
- `I_rst` in 1: synchronous, active-high reset.
- `I_en` in 1: measurement enable.
- `I_div_clk` in 1: divided clock under test, sampled as data.
- `O_ratio` out 8: last measured period in `I_ref_clk` cycles, saturating at 255.
- `O_high_cnt` out 8: high-phase length of the last measured period, in `I_ref_clk` cycles.
- `O_meas_valid` out 1: one-cycle pulse when `O_ratio` / `O_high_cnt` update.
- `O_locked` out 1: ratio stable for `LOCK_CNT` consecutive periods.
- `O_timeout` out 1: no edge seen for 255 cycles in the current phase.

## Operation
- **Synchronizer and edge detect.**
  - Sync chain: `s1 <= I_div_clk`, `s2 <= s1`, `s3 <= s2`.
  - Rise is `s2 & ~s3`; fall is `~s2 & s3`.
- **Phase counters.** `hi_cnt` and `lo_cnt` are 8 bits each.
  - The cycle in which an edge is detected counts as the first cycle of the new phase (counter loads 1).
- **FSM states:** IDLE, HIGH, LOW, TMO.
  - IDLE: counters 0. On rise: `hi_cnt <= 1`, go to HIGH. A level that is already high at enable is ignored until a true rise.
  - HIGH: `hi_cnt++` each cycle. On fall: `lo_cnt <= 1`, go to LOW.
  - LOW: `lo_cnt++` each cycle. On rise: emit a measurement, `hi_cnt <= 1`, go to HIGH.
  - The first rise after IDLE or TMO only starts counting; it emits nothing.
  - Any state → TMO when the active phase counter is 255 and no edge is detected in that cycle.
  - TMO: `O_timeout = 1`. On rise: clear `O_timeout`, `hi_cnt <= 1`, go to HIGH, no emission. A fall in TMO is ignored.
- **Measurement.**
  - `O_ratio = min(hi_cnt + lo_cnt, 255)`, using a 9-bit sum.
  - `O_high_cnt = hi_cnt`.
  - Both are registered and `O_meas_valid` pulses for 1 cycle.
- **Lock.**
  - A 4-bit `match_cnt` tracks repeats.
  - On a measurement equal to the previous `O_ratio`: `match_cnt` increments, saturating at `LOCK_CNT`. Otherwise `match_cnt <= 1`.
  - `O_locked = (match_cnt == LOCK_CNT)`.
  - Entering TMO or IDLE clears `match_cnt` and `O_locked`.
  - The first measurement after IDLE/TMO sets `match_cnt = 1`.
- **Enable.** `I_en = 0` forces IDLE and clears counters, `O_locked`, `O_timeout` and `O_meas_valid`. `O_ratio` and `O_high_cnt` hold.
- **Undetectable inputs.** A divider in bypass (ratio 0/1, output equal to the reference clock) samples constant and reports timeout. Ratio 2 is measurable.

## Timing
- **Reset values:** all outputs 0; FSM IDLE; sync flops 0.
- **Latency:** if rising edge n is the first `I_ref_clk` edge sampling `I_div_clk = 1` after a complete low phase, `O_meas_valid` is high in the cycle after edge n+2. `O_ratio` is valid in the same cycle.
- **Lock:** `O_locked` rises in the same cycle as the `O_meas_valid` of the `LOCK_CNT`-th matching measurement. It falls in the same cycle as a mismatching `O_meas_valid`.
- **Timeout:** `O_timeout` rises the cycle after a phase counter reaches 255 without an edge.
- **Reset and enable mid-period:** `I_rst` takes priority over everything, then `I_en = 0`. A mid-period reset discards the partial period; the next emission needs one full period after a new rise.

## Test plan
- **Ratio 6** (3 high / 3 low), `I_en = 1`: first `O_meas_valid` after the second rise, with `O_ratio = 6` and `O_high_cnt = 3`. `O_locked = 1` on the 4th measurement, then stays high.
- **Ratio 7** (3 high / 4 low) and **ratio 2** (1 / 1): `O_ratio = 7` with `O_high_cnt = 3`; `O_ratio = 2` with `O_high_cnt = 1`. Pulses are spaced exactly 7 or 2 cycles apart.
- **Ratio change:** lock at 4, then switch to 9. The first mismatching measurement drops `O_locked`. Relock follows after 4 periods of `O_ratio = 9`.
- **Stuck input:** hold `I_div_clk` low after lock. `O_timeout = 1` and `O_locked = 0` follow the 255th low cycle. Restarting at ratio 4 clears `O_timeout` on the first rise, and the first `O_meas_valid` comes one period later.
- **Long period:** 200 high / 200 low gives `O_ratio = 255` (saturated) and `O_high_cnt = 200`, with no timeout.
- **Reset and enable mid-HIGH:** assert `I_rst` mid-HIGH, and separately drop `I_en` mid-HIGH. All flags go to 0 next cycle and no `O_meas_valid` appears for the partial period. After `I_en` drop, `O_ratio` holds its prior value.
